iter_alu: RTL and testbench

//  Parametrised, registered successor to the 16-bit datapath ALU. Keeps the eight legacy ops
//  (same encodings 0-7). Adds SLT and iterative unsigned multiply/divide through a

---
 rtl/alu_pkg.sv | 28 ++
 rtl/muldiv_iter.sv | 74 +++++++
 rtl/iter_alu.sv | 139 +++++++++++++
 tb/tb_iter_alu.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative execute-stage ALU:
// op codes, FSM state encoding and counter sizing.
package alu_pkg;

    localparam logic [3:0] OP_PASSB = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_NOTB  = 4'd5;
    localparam logic [3:0] OP_CMPEQ = 4'd6;
    localparam logic [3:0] OP_PASSA = 4'd7;
    localparam logic [3:0] OP_MULU  = 4'd8;
    localparam logic [3:0] OP_DIVU  = 4'd9;
    localparam logic [3:0] OP_SLT   = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // CNT_W for a given WIDTH: enough bits to count 0..WIDTH
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath: shift-add unsigned multiply (mode=0)
// and restoring unsigned divide (mode=1).
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             mode,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             mode_q, mode_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        ge      = shifted >= {1'b0, opnd_q};
        // when ge holds the true difference is below the divisor, so it fits
        diff    = shifted[WIDTH-1:0] - opnd_q;

        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        mode_d = mode_q;
        if (load) begin
            hi_d   = '0;
            lo_d   = a;
            opnd_d = b;
            mode_d = mode;
        end else if (step) begin
            if (mode_q) begin
                hi_d = ge ? diff : shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], ge};
            end else begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            mode_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            mode_q <= mode_d;
        end
    end

    // accumulator values as they stand after this cycle's edge
    assign hi = hi_d;
    assign lo = lo_d;

endmodule

// File: rtl/iter_alu.sv
// Registered execute-stage ALU: single-cycle simple ops plus
// iterative MULU/DIVU behind a start/busy/done handshake.
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             dz
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] simple_res;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic             md_load, md_step;
    logic             is_md;

    always_comb begin
        case (op)
            OP_PASSB: simple_res = b;
            OP_ADD:   simple_res = a + b;
            OP_SUB:   simple_res = a - b;
            OP_AND:   simple_res = a & b;
            OP_OR:    simple_res = a | b;
            OP_NOTB:  simple_res = ~b;
            OP_SLT:   simple_res = {{(WIDTH-1){1'b0}},
                                    $signed(a) < $signed(b)};
            default:  simple_res = a;
        endcase
    end

    assign is_md = (op == OP_MULU) || (op == OP_DIVU);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        dz_d     = dz_q;
        md_load  = 1'b0;
        md_step  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DONE;
                    if (op == OP_DIVU && b == '0) begin
                        result_d = '1;
                        hi_d     = a;
                        zero_d   = 1'b0;
                        dz_d     = 1'b1;
                    end else if (is_md) begin
                        md_load = 1'b1;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        result_d = simple_res;
                        hi_d     = '0;
                        zero_d   = (op == OP_CMPEQ) && (a == b);
                        dz_d     = 1'b0;
                    end
                end
            end
            S_RUN: begin
                md_step = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    result_d = md_lo;
                    hi_d     = md_hi;
                    zero_d   = 1'b0;
                    dz_d     = 1'b0;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            dz_q     <= dz_d;
        end
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_md (
        .clk  (clk),
        .rst  (rst),
        .load (md_load),
        .mode (op == OP_DIVU),
        .step (md_step),
        .a    (a),
        .b    (b),
        .hi   (md_hi),
        .lo   (md_lo)
    );

    assign busy   = state_q != S_IDLE;
    assign done   = state_q == S_DONE;
    assign result = result_q;
    assign hi     = hi_q;
    assign zero   = zero_q;
    assign dz     = dz_q;

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu at WIDTH 16, 8 and 32.
module tb_iter_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start16 = 0, start8 = 0, start32 = 0;
    logic [3:0]  op16 = 0, op8 = 0, op32 = 0;
    logic [15:0] a16 = 0, b16 = 0, res16, hi16;
    logic [7:0]  a8 = 0, b8 = 0, res8, hi8;
    logic [31:0] a32 = 0, b32 = 0, res32, hi32;
    logic        busy16, done16, zero16, dz16;
    logic        busy8, done8, zero8, dz8;
    logic        busy32, done32, zero32, dz32;

    iter_alu #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(res16), .hi(hi16),
        .zero(zero16), .dz(dz16)
    );
    iter_alu #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .hi(hi8),
        .zero(zero8), .dz(dz8)
    );
    iter_alu #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(res32), .hi(hi32),
        .zero(zero32), .dz(dz32)
    );

    typedef struct {
        logic [63:0] res;
        logic [63:0] hi;
        logic        zero;
        logic        dz;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q16[$], q8[$], q32[$];
    int cyc = 0;
    int n_pass = 0, n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_done(input string tag, input int sz, input exp_t e,
                              input logic [63:0] r, input logic [63:0] h,
                              input logic z, input logic d);
        chk({tag, " done expected"}, 64'(sz != 0), 64'd1);
        if (sz != 0) begin
            chk({e.name, " result"}, r, e.res);
            chk({e.name, " hi"}, h, e.hi);
            chk({e.name, " zero"}, 64'(z), 64'(e.zero));
            chk({e.name, " dz"}, 64'(d), 64'(e.dz));
            chk({e.name, " done cycle"}, 64'(cyc), 64'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int sz;
        if (done16) begin
            sz = q16.size();
            if (sz != 0) e = q16.pop_front();
            check_done("w16", sz, e, 64'(res16), 64'(hi16), zero16, dz16);
        end
        if (done8) begin
            sz = q8.size();
            if (sz != 0) e = q8.pop_front();
            check_done("w8", sz, e, 64'(res8), 64'(hi8), zero8, dz8);
        end
        if (done32) begin
            sz = q32.size();
            if (sz != 0) e = q32.pop_front();
            check_done("w32", sz, e, 64'(res32), 64'(hi32), zero32, dz32);
        end
    end

    task automatic issue(input int w, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] er, input logic [63:0] eh,
                         input logic ez, input logic ed, input int lat,
                         input string name, input bit push = 1'b1);
        exp_t e;
        @(negedge clk);
        e.res = er; e.hi = eh; e.zero = ez; e.dz = ed;
        e.cyc = cyc + lat; e.name = name;
        case (w)
            8: begin
                op8 = op; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
                if (push) q8.push_back(e);
            end
            32: begin
                op32 = op; a32 = a[31:0]; b32 = b[31:0]; start32 = 1'b1;
                if (push) q32.push_back(e);
            end
            default: begin
                op16 = op; a16 = a[15:0]; b16 = b[15:0]; start16 = 1'b1;
                if (push) q16.push_back(e);
            end
        endcase
        @(posedge clk);
        #1;
        start8 = 1'b0; start16 = 1'b0; start32 = 1'b0;
    endtask

    task automatic wait_idle(input int w, input string name);
        logic bz;
        bz = 1'b1;
        for (int i = 0; i < 200 && bz; i++) begin
            @(negedge clk);
            case (w)
                8:       bz = busy8;
                32:      bz = busy32;
                default: bz = busy16;
            endcase
        end
        chk({name, " returns idle"}, 64'(bz), 64'd0);
    endtask

    initial begin
        logic busy_all;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", 64'(busy16), 0);
        chk("reset done", 64'(done16), 0);
        chk("reset result", 64'(res16), 0);
        chk("reset hi", 64'(hi16), 0);
        chk("reset zero", 64'(zero16), 0);
        chk("reset dz", 64'(dz16), 0);
        chk("reset w32 result", 64'(res32), 0);

        issue(16, OP_ADD, 'hFFFF, 1, 0, 0, 0, 0, 1, "add wrap");
        wait_idle(16, "add wrap");
        issue(16, OP_SUB, 0, 1, 'hFFFF, 0, 0, 0, 1, "sub wrap");
        wait_idle(16, "sub wrap");
        issue(16, OP_CMPEQ, 'h1234, 'h1234, 'h1234, 0, 1, 0, 1, "cmpeq eq");
        wait_idle(16, "cmpeq eq");
        issue(16, OP_CMPEQ, 'h1234, 'h1235, 'h1234, 0, 0, 0, 1, "cmpeq ne");
        wait_idle(16, "cmpeq ne");
        issue(16, OP_SLT, 'h8000, 1, 1, 0, 0, 0, 1, "slt neg");
        wait_idle(16, "slt neg");
        issue(16, OP_SLT, 1, 'h8000, 0, 0, 0, 0, 1, "slt pos");
        wait_idle(16, "slt pos");
        issue(16, OP_AND, 'hF0F0, 'h3C3C, 'h3030, 0, 0, 0, 1, "and");
        wait_idle(16, "and");
        issue(16, OP_OR, 'hF0F0, 'h0F01, 'hFFF1, 0, 0, 0, 1, "or");
        wait_idle(16, "or");
        issue(16, OP_NOTB, 'h1111, 'h00FF, 'hFF00, 0, 0, 0, 1, "notb");
        wait_idle(16, "notb");
        issue(16, OP_PASSB, 'h1111, 'hABCD, 'hABCD, 0, 0, 0, 1, "passb");
        wait_idle(16, "passb");
        issue(16, OP_PASSA, 'h5A5A, 'hABCD, 'h5A5A, 0, 0, 0, 1, "passa");
        wait_idle(16, "passa");
        issue(16, 4'd13, 'h7777, 'h1234, 'h7777, 0, 0, 0, 1, "reserved");
        wait_idle(16, "reserved");

        issue(16, OP_MULU, 'hFFFF, 'hFFFF, 'h0001, 'hFFFE, 0, 0, 17, "mulu16");
        busy_all = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            busy_all &= busy16;
        end
        chk("mulu16 busy cycles 1..17", 64'(busy_all), 1);
        @(negedge clk);
        chk("mulu16 idle at cycle 18", 64'(busy16), 0);

        issue(16, OP_DIVU, 100, 7, 14, 2, 0, 0, 17, "divu16");
        @(negedge clk);
        start16 = 1'b1; op16 = OP_ADD; a16 = 16'd5; b16 = 16'd5;
        @(posedge clk);
        #1 start16 = 1'b0;
        a16 = 16'h9999; b16 = 16'h0003;
        @(negedge clk);
        chk("run start ignored result", 64'(res16), 'h0001);
        chk("run start ignored hi", 64'(hi16), 'hFFFE);
        wait_idle(16, "divu16");

        issue(16, OP_DIVU, 'h1234, 0, 'hFFFF, 'h1234, 0, 1, 1, "divu16 dz");
        wait_idle(16, "divu16 dz");
        repeat (3) @(negedge clk);
        chk("sticky result", 64'(res16), 'hFFFF);
        chk("sticky dz", 64'(dz16), 1);

        issue(16, OP_MULU, 3, 4, 0, 0, 0, 0, 0, "abort", 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort busy", 64'(busy16), 0);
        chk("abort result", 64'(res16), 0);
        chk("abort hi", 64'(hi16), 0);
        chk("abort dz", 64'(dz16), 0);
        repeat (20) @(negedge clk);
        issue(16, OP_ADD, 2, 3, 5, 0, 0, 0, 1, "add after abort");
        wait_idle(16, "add after abort");

        issue(8, OP_MULU, 'hFF, 'hFF, 'h01, 'hFE, 0, 0, 9, "mulu8");
        wait_idle(8, "mulu8");
        issue(8, OP_DIVU, 200, 9, 22, 2, 0, 0, 9, "divu8");
        wait_idle(8, "divu8");
        issue(32, OP_MULU, 'hFFFF_FFFF, 'hFFFF_FFFF, 'h1, 'hFFFF_FFFE,
              0, 0, 33, "mulu32");
        wait_idle(32, "mulu32");
        issue(32, OP_MULU, 'h1234_5678, 'h10, 'h2345_6780, 'h1,
              0, 0, 33, "mulu32 shift");
        wait_idle(32, "mulu32 shift");

        repeat (5) @(negedge clk);
        chk("w16 queue drained", 64'(q16.size()), 0);
        chk("w8 queue drained", 64'(q8.size()), 0);
        chk("w32 queue drained", 64'(q32.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
